jt6295_serial_n: RTL and testbench
==================================

Name: jt6295_serial_n

Overview:
- Parametrised time-multiplexed ADPCM channel sequencer: N channels share one ROM port and one serial output pipe, one channel slot per `cen`.
- Feeds the ADPCM decoder/accumulator downstream and replaces the fixed 4-channel serialiser.
- Features beyond the fixed version:
  - configurable channel count and address width;
  - per-channel loop mode;
  - per-channel pending-request latching;
  - ROM-ready qualification;
  - explicit output channel index.

Parameters:
- CH, 4, number of channels (2..16).
- AW, 18, ROM byte-address width.
- ATTW, 4, attenuation code width.
- CW, $clog2(CH), channel index width (derived, do not override).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cen  in  1  slot advance enable.
- start_addr  in  AW  sample start byte address, shared by all channels.
- stop_addr  in  AW  sample last byte address, shared by all channels.
- att  in  ATTW  attenuation, captured at start.
- loop_in  in  1  loop mode, captured at start.
- start  in  CH  one-hot-per-bit start pulses, any clk.
- stop  in  CH  stop pulses, any clk.
- busy  out  CH  channel playing.
- rom_addr  out  AW  byte address for current slot.
- rom_data  in  8  ROM byte.
- rom_ok  in  1  rom_data valid for rom_addr.
- pipe_en  out  1  pipe_data valid for decoding.
- pipe_ch  out  CW  channel of pipe outputs.
- pipe_att  out  ATTW  attenuation of pipe outputs.
- pipe_data  out  4  ADPCM nibble.

Behaviour:
- Reset (async, rst_n low):
  - all per-channel state = 0: busy, cnt, stop, loop, att and the start/stop latches;
  - slot index = 0;
  - pipe_en = 0, pipe_ch = 0, pipe_att = 0, pipe_data = 0, rom_addr = 0.
  - Reset mid-play aborts all channels immediately.
- Slot index:
  - increments on each `cen`, wrapping CH-1 -> 0;
  - rom_addr is combinational from the current slot's counter.
- Per-channel state:
  - nibble counter cnt[AW:0], nibble stop address stp[AW:0], start nibble sta[AW:0], att, loop, busy;
  - rom_addr = cnt[AW:1];
  - even nibble selects rom_data[7:4], odd nibble selects rom_data[3:0].
- Request latches:
  - start[i] and stop[i] are OR-ed into sticky pending bits on every clk;
  - a pending bit is cleared only in the cen cycle where slot == i consumes it. Other channels' requests are never lost.
  - A new pulse in the same clk as consumption re-arms the latch.
- Slot update at cen, for channel i = slot:
  - start pending (wins over stop pending):
    - sta = cnt = {start_addr, 0};
    - stp = {stop_addr, 1};
    - att = att, loop = loop_in, busy = 1.
  - else stop pending: busy = 0.
  - else busy and cnt == stp:
    - loop = 1: cnt = sta, busy stays 1;
    - loop = 0: busy = 0.
    - The stop nibble itself is emitted before busy clears.
  - else busy: cnt = cnt + 1, wrapping modulo 2^(AW+1).
  - Idle channel: no change.
- busy[i] output updates on that channel's slot cen only.
- Output pipe:
  - stage-1 register at slot cen captures: channel index, nibble select cnt[0], att, and en = busy-before-update.
  - At the next cen:
    - pipe_data = selected nibble of rom_data;
    - pipe_ch, pipe_att copied from stage 1;
    - pipe_en = en & rom_ok.
  - Latency: slot cen n -> pipe outputs valid after cen n+1. Outputs hold between cens.
  - When rom_ok = 0 at sampling: pipe_en = 0, pipe_data = 0, and the counter still advances (nibble dropped, no stall).
- A start for a busy channel restarts it at its next slot.
- start_addr == stop_addr is legal: two nibbles are played.

Decomposition:
- Shared package/header jt6295_pkg: nibble-select encoding constant and default CH/AW/ATTW values.
- One sub-module, jt6295_req_latch:
  - CH-bit sticky request latch with per-bit clear;
  - instantiated twice, for start and for stop.
- Per-channel state is held in register arrays indexed by slot. No shift-ring.

Test Plan:
- Reset: hold rst_n = 0 mid-play with channels 0 and 2 busy.
  -> busy = 0, pipe_en = 0, rom_addr = 0 asynchronously; slot = 0 after release.
- Start ch1 with start_addr = 0x00100, stop_addr = 0x00101, rom_data = 0xA5/0x3C, CH = 4.
  -> four pipe_en pulses with pipe_ch = 1, data sequence 0xA, 0x5, 0x3, 0xC.
  -> busy[1] falls at the slot after the 4th nibble.
- Loop: ch3 with loop_in = 1, start_addr = stop_addr = 0x20.
  -> nibbles cycle 0x20 hi, 0x20 lo indefinitely; busy[3] stays 1.
  -> stop[3] pulse gives busy[3] = 0 at ch3's next slot.
- Simultaneous requests: start = 4'b1111 in one clk between cens.
  -> each channel starts at its own slot; none lost; busy ramps 0001, 0011, 0111, 1111 over 4 cens.
- Start and stop on ch0 in the same clk.
  -> channel restarts (start wins) and busy[0] = 1.
- rom_ok = 0 for one sample of ch2.
  -> that slot gives pipe_en = 0, pipe_data = 0; the next ch2 slot emits the following nibble (address advanced).

Source files
------------

// File: rtl/jt6295_pkg.sv
// Shared definitions for the jt6295 channel sequencer: default sizes and the
// nibble-select encoding used when splitting a ROM byte into ADPCM nibbles.
package jt6295_pkg;

    localparam int DEF_CH   = 4;
    localparam int DEF_AW   = 18;
    localparam int DEF_ATTW = 4;

    // Even nibble addresses (bit 0 clear) play the high half of the byte first
    localparam logic NIB_HI = 1'b0;

    function automatic logic [3:0] nib_sel(input logic [7:0] data, input logic sel);
        return (sel == NIB_HI) ? data[7:4] : data[3:0];
    endfunction

endpackage

// File: rtl/jt6295_serial_n_if.sv
// ROM port and serial output pipe of the jt6295 channel sequencer.
// The sequencer is the master: it drives the ROM address and the pipe outputs.
interface jt6295_serial_n_if
    import jt6295_pkg::*;
#(
    parameter int AW   = DEF_AW,
    parameter int ATTW = DEF_ATTW,
    parameter int CW   = 2
);
    logic [AW-1:0]   rom_addr;
    logic [7:0]      rom_data;
    logic            rom_ok;
    logic            pipe_en;
    logic [CW-1:0]   pipe_ch;
    logic [ATTW-1:0] pipe_att;
    logic [3:0]      pipe_data;

    modport master (
        output rom_addr, pipe_en, pipe_ch, pipe_att, pipe_data,
        input  rom_data, rom_ok
    );

    modport slave (
        input  rom_addr, pipe_en, pipe_ch, pipe_att, pipe_data,
        output rom_data, rom_ok
    );
endinterface

// File: rtl/jt6295_req_latch.sv
// Sticky request latch: each bit is set by a pulse and held until the owning
// channel's slot consumes it. A pulse arriving in the consume cycle re-arms it.
module jt6295_req_latch
    import jt6295_pkg::*;
#(
    parameter int CH = DEF_CH
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] set,
    input  logic [CH-1:0] clr,
    output logic [CH-1:0] pend
);

    // Clear consumed bits first, then OR in new pulses so none are lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~clr) | set;
        end
    end

endmodule

// File: rtl/jt6295_serial_n.sv
// Time-multiplexed ADPCM channel sequencer. CH channels take turns, one slot
// per cen, sharing one ROM port and one serial nibble pipe towards the decoder.
// Per-channel state lives in arrays indexed by the current slot.
module jt6295_serial_n
    import jt6295_pkg::*;
#(
    parameter int CH   = DEF_CH,
    parameter int AW   = DEF_AW,
    parameter int ATTW = DEF_ATTW,
    parameter int CW   = $clog2(CH)
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen,
    input  logic [AW-1:0]   start_addr,
    input  logic [AW-1:0]   stop_addr,
    input  logic [ATTW-1:0] att,
    input  logic            loop_in,
    input  logic [CH-1:0]   start,
    input  logic [CH-1:0]   stop,
    output logic [CH-1:0]   busy,
    jt6295_serial_n_if.master bus
);

    logic [CW-1:0]   slot;

    // Nibble addresses: bit 0 selects the half of the ROM byte
    logic [AW:0]     cnt   [CH];
    logic [AW:0]     stp   [CH];
    logic [AW:0]     sta   [CH];
    logic [ATTW-1:0] att_r [CH];
    logic [CH-1:0]   loop_r;
    logic [CH-1:0]   busy_r;

    logic [CH-1:0]   st_pend;
    logic [CH-1:0]   sp_pend;
    logic [CH-1:0]   slot_clr;
    logic [AW:0]     cur_cnt;

    // Stage 1: what the current slot asked the ROM for
    logic [CW-1:0]   ch_p1;
    logic            nsel_p1;
    logic [ATTW-1:0] att_p1;
    logic            vld_p1;

    assign cur_cnt      = cnt[slot];
    assign bus.rom_addr = cur_cnt[AW:1];
    assign busy         = busy_r;

    // One-hot clear for the channel whose slot consumes its requests this cen
    always_comb begin
        slot_clr = '0;
        for (int i = 0; i < CH; i++) begin
            slot_clr[i] = cen && (slot == CW'(i));
        end
    end

    jt6295_req_latch #(.CH(CH)) u_start_latch (
        .clk   (clk),
        .rst_n (rst_n),
        .set   (start),
        .clr   (slot_clr),
        .pend  (st_pend)
    );

    jt6295_req_latch #(.CH(CH)) u_stop_latch (
        .clk   (clk),
        .rst_n (rst_n),
        .set   (stop),
        .clr   (slot_clr),
        .pend  (sp_pend)
    );

    // Slot index walks 0..CH-1 and wraps, one step per cen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (cen) begin
            slot <= (slot == CW'(CH - 1)) ? '0 : slot + CW'(1);
        end
    end

    // Per-channel playback update for the channel owning this slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                cnt[i]   <= '0;
                stp[i]   <= '0;
                sta[i]   <= '0;
                att_r[i] <= '0;
            end
            loop_r <= '0;
            busy_r <= '0;
        end else if (cen) begin
            if (st_pend[slot]) begin
                // Start beats a simultaneous stop; also restarts a busy channel
                cnt[slot]    <= {start_addr, 1'b0};
                sta[slot]    <= {start_addr, 1'b0};
                stp[slot]    <= {stop_addr, 1'b1};
                att_r[slot]  <= att;
                loop_r[slot] <= loop_in;
                busy_r[slot] <= 1'b1;
            end else if (sp_pend[slot]) begin
                busy_r[slot] <= 1'b0;
            end else if (busy_r[slot]) begin
                if (cur_cnt == stp[slot]) begin
                    // Stop nibble is being fetched now; end or rewind afterwards
                    if (loop_r[slot]) begin
                        cnt[slot] <= sta[slot];
                    end else begin
                        busy_r[slot] <= 1'b0;
                    end
                end else begin
                    cnt[slot] <= cur_cnt + {{AW{1'b0}}, 1'b1};
                end
            end
        end
    end

    // Stage 1 capture: remember which channel/nibble the ROM is fetching
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_p1   <= '0;
            nsel_p1 <= 1'b0;
            att_p1  <= '0;
            vld_p1  <= 1'b0;
        end else if (cen) begin
            ch_p1   <= slot;
            nsel_p1 <= cur_cnt[0];
            att_p1  <= att_r[slot];
            vld_p1  <= busy_r[slot];
        end
    end

    // Stage 2 output: sample the ROM byte; a not-ready ROM drops the nibble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pipe_en   <= 1'b0;
            bus.pipe_ch   <= '0;
            bus.pipe_att  <= '0;
            bus.pipe_data <= '0;
        end else if (cen) begin
            bus.pipe_en   <= vld_p1 & bus.rom_ok;
            bus.pipe_ch   <= ch_p1;
            bus.pipe_att  <= att_p1;
            bus.pipe_data <= bus.rom_ok ? nib_sel(bus.rom_data, nsel_p1) : 4'h0;
        end
    end

endmodule

// File: tb/tb_jt6295_serial_n.sv
// Bench for jt6295_serial_n: directed steps from the test plan followed by a
// random phase, all compared against a sample-level playback model.
module tb_jt6295_serial_n;

    localparam int CH   = 4;
    localparam int AW   = 18;
    localparam int ATTW = 4;
    localparam int CW   = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cen;
    logic [AW-1:0]   start_addr;
    logic [AW-1:0]   stop_addr;
    logic [ATTW-1:0] att;
    logic            loop_in;
    logic [CH-1:0]   start;
    logic [CH-1:0]   stop;
    logic [CH-1:0]   busy;

    jt6295_serial_n_if #(.AW(AW), .ATTW(ATTW), .CW(CW)) bus ();

    jt6295_serial_n #(.CH(CH), .AW(AW), .ATTW(ATTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen        (cen),
        .start_addr (start_addr),
        .stop_addr  (stop_addr),
        .att        (att),
        .loop_in    (loop_in),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // ROM contents: two fixed bytes for the directed test, a hash elsewhere
    function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
        if (a == AW'(32'h100)) return 8'hA5;
        if (a == AW'(32'h101)) return 8'h3C;
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    // Synchronous ROM: address presented in a slot, byte ready by the next cen
    always @(posedge clk) begin
        if (cen) bus.rom_data <= rom_byte(bus.rom_addr);
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Playback model: a sample is a base nibble address, a length and a position
    int              m_base [CH];
    int              m_len  [CH];
    int              m_pos  [CH];
    logic [ATTW-1:0] m_att  [CH];
    logic            m_loop [CH];
    logic [CH-1:0]   m_busy;
    logic [CH-1:0]   pst;
    logic [CH-1:0]   psp;
    int              m_slot;
    logic            cap_en;
    int              cap_ch;
    logic [ATTW-1:0] cap_att;
    int              cap_addr;
    logic            cap_known;
    logic            ok_v;
    int              en_cnt;
    logic [15:0]     seq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_nib(input int n);
        logic [7:0] b;
        b = rom_byte(AW'(n / 2));
        return ((n % 2) == 1) ? b[3:0] : b[7:4];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_base[i] = 0;
            m_len[i]  = 1;
            m_pos[i]  = 0;
            m_att[i]  = '0;
            m_loop[i] = 1'b0;
        end
        m_busy    = '0;
        pst       = '0;
        psp       = '0;
        m_slot    = 0;
        cap_en    = 1'b0;
        cap_ch    = 0;
        cap_att   = '0;
        cap_addr  = 0;
        cap_known = 1'b0;
    endtask

    task automatic pulse(input logic [CH-1:0] st, input logic [CH-1:0] sp);
        @(negedge clk);
        start = st;
        stop  = sp;
        pst   = pst | st;
        psp   = psp | sp;
        @(posedge clk);
        #1;
        start = '0;
        stop  = '0;
    endtask

    // One slot: a cen clock followed by an idle clock
    task automatic tick();
        logic            e_en;
        int              e_ch;
        logic [ATTW-1:0] e_att;
        logic [3:0]      e_data;
        logic            e_dk;
        int              s;
        @(negedge clk);
        cen = 1'b1;
        bus.rom_ok = ok_v;
        e_en   = cap_en & ok_v;
        e_ch   = cap_ch;
        e_att  = cap_att;
        e_dk   = cap_known | !ok_v;
        e_data = ok_v ? exp_nib(cap_addr) : 4'h0;
        s = m_slot;
        cap_en    = m_busy[s];
        cap_ch    = s;
        cap_att   = m_att[s];
        cap_addr  = m_base[s] + m_pos[s];
        cap_known = 1'b1;
        if (pst[s]) begin
            m_base[s] = 2 * int'(start_addr);
            m_len[s]  = 2 * int'(stop_addr) + 2 - m_base[s];
            m_pos[s]  = 0;
            m_att[s]  = att;
            m_loop[s] = loop_in;
            m_busy[s] = 1'b1;
        end else if (psp[s]) begin
            m_busy[s] = 1'b0;
        end else if (m_busy[s]) begin
            if (m_pos[s] == m_len[s] - 1) begin
                if (m_loop[s]) m_pos[s] = 0;
                else m_busy[s] = 1'b0;
            end else begin
                m_pos[s] = m_pos[s] + 1;
            end
        end
        pst[s] = 1'b0;
        psp[s] = 1'b0;
        m_slot = (s + 1) % CH;
        @(posedge clk);
        #1;
        check("pipe_en",  32'(bus.pipe_en),  32'(e_en));
        check("pipe_ch",  32'(bus.pipe_ch),  32'(e_ch));
        check("pipe_att", 32'(bus.pipe_att), 32'(e_att));
        if (e_dk) check("pipe_data", 32'(bus.pipe_data), 32'(e_data));
        check("busy", 32'(busy), 32'(m_busy));
        check("rom_addr", 32'(bus.rom_addr), 32'((m_base[m_slot] + m_pos[m_slot]) / 2));
        if (bus.pipe_en && bus.pipe_ch == CW'(1)) begin
            en_cnt++;
            seq = {seq[11:0], bus.pipe_data};
        end
        @(negedge clk);
        cen = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        cen        = 1'b0;
        start      = '0;
        stop       = '0;
        start_addr = '0;
        stop_addr  = '0;
        att        = '0;
        loop_in    = 1'b0;
        ok_v       = 1'b1;
        bus.rom_ok = 1'b1;
        en_cnt     = 0;
        seq        = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",     32'(busy),          32'h0);
        check("rst_pipe_en",  32'(bus.pipe_en),   32'h0);
        check("rst_pipe_ch",  32'(bus.pipe_ch),   32'h0);
        check("rst_pipe_att", 32'(bus.pipe_att),  32'h0);
        check("rst_pipe_dat", 32'(bus.pipe_data), 32'h0);
        check("rst_rom_addr", 32'(bus.rom_addr),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single sample on ch1: bytes A5, 3C give nibbles A,5,3,C
        start_addr = AW'(32'h100);
        stop_addr  = AW'(32'h101);
        att        = 4'h5;
        pulse(4'b0010, 4'b0000);
        repeat (24) tick();
        check("t1_count", 32'(en_cnt), 32'd4);
        check("t1_seq",   32'(seq),    32'hA53C);
        check("t1_busy1", 32'(busy[1]), 32'h0);

        // Looping two-nibble sample on ch3, then stopped
        start_addr = AW'(32'h20);
        stop_addr  = AW'(32'h20);
        att        = 4'h9;
        loop_in    = 1'b1;
        pulse(4'b1000, 4'b0000);
        repeat (24) tick();
        check("loop_busy3", 32'(busy[3]), 32'h1);
        loop_in = 1'b0;
        pulse(4'b0000, 4'b1000);
        repeat (4) tick();
        check("loop_stop3", 32'(busy[3]), 32'h0);

        // All four channels requested at once: busy ramps one slot at a time
        while (m_slot != 0) tick();
        start_addr = AW'(32'h40);
        stop_addr  = AW'(32'h47);
        att        = 4'h3;
        pulse(4'b1111, 4'b0000);
        tick();
        check("ramp1", 32'(busy), 32'h1);
        tick();
        check("ramp2", 32'(busy), 32'h3);
        tick();
        check("ramp3", 32'(busy), 32'h7);
        tick();
        check("ramp4", 32'(busy), 32'hF);
        repeat (80) tick();

        // Start and stop together on ch0: start wins
        start_addr = AW'(32'h200);
        stop_addr  = AW'(32'h205);
        pulse(4'b0001, 4'b0001);
        repeat (4) tick();
        check("startstop_busy0", 32'(busy[0]), 32'h1);

        // ROM not ready for one ch2 sample: nibble dropped, address still advances
        start_addr = AW'(32'h300);
        stop_addr  = AW'(32'h303);
        att        = 4'hC;
        pulse(4'b0100, 4'b0000);
        repeat (9) tick();
        while (m_slot != 3) tick();
        ok_v = 1'b0;
        tick();
        check("drop_en",   32'(bus.pipe_en),   32'h0);
        check("drop_data", 32'(bus.pipe_data), 32'h0);
        ok_v = 1'b1;
        repeat (8) tick();

        // Mid-play reset with channels 0 and 2 busy
        start_addr = AW'(32'h500);
        stop_addr  = AW'(32'h520);
        pulse(4'b0101, 4'b0000);
        repeat (8) tick();
        check("pre_rst_busy", 32'(busy & 4'b0101), 32'h5);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",     32'(busy),         32'h0);
        check("arst_pipe_en",  32'(bus.pipe_en),  32'h0);
        check("arst_rom_addr", 32'(bus.rom_addr), 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) tick();

        // Random traffic
        for (int it = 0; it < 300; it++) begin
            start_addr = AW'($urandom_range(0, 32'h3FFF0));
            stop_addr  = start_addr + AW'($urandom_range(0, 3));
            att        = ATTW'($urandom);
            loop_in    = ($urandom_range(0, 7) == 0);
            ok_v       = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0)
                pulse(CH'($urandom), ($urandom_range(0, 4) == 0) ? CH'($urandom) : CH'(0));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
